// File: rtl/select_bus_arbiter.sv
// Round-robin arbiter and sequencer for the 4-way tri-state select bus.
// Grants one source at a time, limits tenure under contention, and inserts
// turnaround cycles with enable low between owners.
module select_bus_arbiter #(
    parameter int unsigned MAX_TENURE  = 8,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] s,
    output logic       enable,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_t;

    localparam logic [7:0] TENURE_MAX = 8'(MAX_TENURE);
    localparam logic [3:0] TURN_LAST  = 4'(TURN_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] s_q, s_d;
    logic       enable_q, enable_d;
    logic       busy_q, busy_d;
    logic [7:0] tenure_q, tenure_d;
    logic [3:0] turn_q, turn_d;
    logic [1:0] last_q, last_d;

    logic [1:0] win_idx;
    logic [3:0] owner_oh;
    logic       release_now;

    // Round-robin pick starting after the last owner; the last owner itself
    // is visited last so it only wins when nobody else is asking.
    always_comb begin
        win_idx = last_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (req[last_q + 2'(4 - i)]) begin
                win_idx = last_q + 2'(4 - i);
            end
        end
    end

    // Release when the owner lets go, or when its tenure is used up and
    // another source is waiting.
    always_comb begin
        owner_oh    = 4'b0001 << s_q;
        release_now = !req[s_q] ||
                      ((tenure_q == TENURE_MAX) && ((req & ~owner_oh) != 4'b0000));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        s_d      = s_q;
        enable_d = enable_q;
        tenure_d = tenure_q;
        turn_d   = turn_q;
        last_d   = last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_d  = ST_GRANT;
                    gnt_d    = 4'b0001 << win_idx;
                    s_d      = win_idx;
                    enable_d = 1'b1;
                    tenure_d = 8'd1;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d  = ST_TURN;
                    gnt_d    = '0;
                    enable_d = 1'b0;
                    last_d   = s_q;
                    turn_d   = 4'd1;
                end else if (tenure_q != TENURE_MAX) begin
                    tenure_d = tenure_q + 8'd1;
                end
            end
            ST_TURN: begin
                if (turn_q >= TURN_LAST) begin
                    if (req != 4'b0000) begin
                        state_d  = ST_GRANT;
                        gnt_d    = 4'b0001 << win_idx;
                        s_d      = win_idx;
                        enable_d = 1'b1;
                        tenure_d = 8'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_d = turn_q + 4'd1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                enable_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            s_q      <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            tenure_q <= '0;
            turn_q   <= '0;
            last_q   <= 2'd3;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            s_q      <= s_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            tenure_q <= tenure_d;
            turn_q   <= turn_d;
            last_q   <= last_d;
        end
    end

    assign gnt    = gnt_q;
    assign s      = s_q;
    assign enable = enable_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_select_bus_arbiter.sv
// Bench for select_bus_arbiter: table vectors, hand-written corner
// sequences, and randomized requests against a behavioural model.
module tb_select_bus_arbiter;

    localparam int MT = 4;
    localparam int TC = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       enable;
    logic       busy;

    int total = 0;
    int bad = 0;

    select_bus_arbiter #(
        .MAX_TENURE (MT),
        .TURN_CYCLES(TC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .s     (s),
        .enable(enable),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] s;
        logic       en;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] sv, input logic e, input logic b);
        vec_t v;
        v.req = r; v.gnt = g; v.s = sv; v.en = e; v.busy = b;
        vecs.push_back(v);
    endfunction

    // Outputs packed as {gnt, s, enable, busy}.
    task automatic check(input string name, input logic [3:0] g, input logic [1:0] sv,
                         input logic e, input logic b);
        logic [7:0] act;
        logic [7:0] exp;
        act = {gnt, s, enable, busy};
        exp = {g, sv, e, b};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got gnt=%b s=%0d en=%b busy=%b, want gnt=%b s=%0d en=%b busy=%b",
                     name, gnt, s, enable, busy, g, sv, e, b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        #2;
        check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural model: owner index (-1 = none), cycles held, gap remaining.
    int m_owner, m_ten, m_gap, m_last, m_s;

    function automatic void m_reset();
        m_owner = -1; m_ten = 0; m_gap = 0; m_last = 3; m_s = 0;
    endfunction

    function automatic void m_try_grant(input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            int j;
            j = (m_last + k) % 4;
            if (r[j]) begin
                m_owner = j; m_s = j; m_ten = 1;
                return;
            end
        end
    endfunction

    function automatic void m_step(input logic [3:0] r);
        if (m_owner >= 0) begin
            logic [3:0] others;
            others = r & ~(4'b0001 << m_owner);
            if (!r[m_owner] || (m_ten == MT && others != 4'b0000)) begin
                m_last = m_owner; m_owner = -1; m_gap = TC;
            end else if (m_ten < MT) begin
                m_ten++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_try_grant(r);
        end else begin
            m_try_grant(r);
        end
    endfunction

    initial begin
        int seq[4];
        // Single request then full contention, starting from reset.
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) add(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
        add(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        seq = '{1, 2, 3, 0};
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 4; t++)
                add(4'b1111, 4'b0001 << seq[k], 2'(seq[k]), 1'b1, 1'b1);
            if (k < 3) add(4'b1111, 4'b0000, 2'(seq[k]), 1'b0, 1'b1);
        end

        #1;
        check("reset_async_initial", 4'b0000, 2'd0, 1'b0, 1'b0);
        do_reset();
        foreach (vecs[i]) begin
            req = vecs[i].req;
            tick();
            check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].s, vecs[i].en, vecs[i].busy);
        end

        // Uncontended hold: no gap, no turnaround.
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold", 4'b0100, 2'd2, 1'b1, 1'b1);
        end

        // Preemption: req[3] rises during owner 1's second grant cycle.
        do_reset();
        req = 4'b0010;
        tick(); check("pre_g1", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick(); check("pre_g2", 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b1010;
        tick(); check("pre_g3", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick(); check("pre_g4", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick(); check("pre_gap", 4'b0000, 2'd1, 1'b0, 1'b1);
        tick(); check("pre_new", 4'b1000, 2'd3, 1'b1, 1'b1);

        // Owner drops req on the same edge its tenure limit hits.
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            tick(); check("sim_grant", 4'b0001, 2'd0, 1'b1, 1'b1);
        end
        req = 4'b0100;
        tick(); check("sim_gap", 4'b0000, 2'd0, 1'b0, 1'b1);
        tick(); check("sim_new", 4'b0100, 2'd2, 1'b1, 1'b1);
        tick(); check("sim_hold", 4'b0100, 2'd2, 1'b1, 1'b1);

        // Asynchronous reset between edges while owner 1 holds the bus.
        do_reset();
        req = 4'b0010;
        tick(); check("ar_grant", 4'b0010, 2'd1, 1'b1, 1'b1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_async", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); check("ar_ptr", 4'b0001, 2'd0, 1'b1, 1'b1);

        // Randomized requests against the model.
        do_reset();
        m_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] eg;
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            @(posedge clk);
            m_step(req);
            #1;
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            check("rand", eg, 2'(m_s), (m_owner >= 0), (m_owner >= 0) || (m_gap > 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
